poly_mem_init: RTL

- Parametrised successor of the single-bank polynomial clear engine.
- Writes a contiguous coefficient region (base, len) into one or more polynomial RAM banks.
- Three fill modes: zero, constant, or index ramp.
- Supports memory back-pressure (stall) and abort; used ahead of every multiply/reduce pass to initialise accumulators and test patterns.

---
 rtl/poly_mem_init_pkg.sv | 25 ++
 rtl/poly_mem_init_dp.sv | 87 ++++++++
 rtl/poly_mem_init_fsm.sv | 61 ++++++
 rtl/poly_mem_init.sv | 67 ++++++
 4 files changed

// File: rtl/poly_mem_init_pkg.sv
// Shared types and helpers for the polynomial memory initialiser.
package poly_mem_init_pkg;

    typedef enum logic [1:0] {
        MODE_ZERO  = 2'd0,
        MODE_CONST = 2'd1,
        MODE_INDEX = 2'd2
    } fill_mode_e;

    // Controller states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WRITE = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // The reserved encoding falls back to a zero fill.
    function automatic fill_mode_e decode_mode(input logic [1:0] mode);
        case (mode)
            2'd1:    return MODE_CONST;
            2'd2:    return MODE_INDEX;
            default: return MODE_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/poly_mem_init_dp.sv
// Datapath: latched request, word counter, address adder, fill-data mux, output registers.
module poly_mem_init_dp
    import poly_mem_init_pkg::*;
#(
    parameter int unsigned DATA_W    = 26,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned NUM_BANKS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 accept,
    input  logic                 advance,
    input  logic                 write_next,
    input  logic [1:0]           mode,
    input  logic [ADDR_W-1:0]    base,
    input  logic [ADDR_W:0]      len,
    input  logic [DATA_W-1:0]    fill_value,
    input  logic [NUM_BANKS-1:0] bank_mask,
    output logic                 last,
    output logic [DATA_W-1:0]    mem_input,
    output logic [ADDR_W-1:0]    mem_address_i,
    output logic [NUM_BANKS-1:0] write_enable
);

    localparam logic [ADDR_W:0] ONE = 1;

    fill_mode_e            mode_q, mode_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [ADDR_W:0]       len_q, len_d;
    logic [DATA_W-1:0]     fill_q, fill_d;
    logic [NUM_BANKS-1:0]  mask_q, mask_d;
    logic [ADDR_W:0]       i_q, i_d;
    logic [ADDR_W-1:0]     addr_d;
    logic [DATA_W-1:0]     data_d;

    // The accepting edge must already present word 0, so use the live request then
    always_comb begin
        mode_d = accept ? decode_mode(mode) : mode_q;
        base_d = accept ? base : base_q;
        len_d  = accept ? len : len_q;
        fill_d = accept ? fill_value : fill_q;
        mask_d = accept ? bank_mask : mask_q;
        if (accept)       i_d = '0;
        else if (advance) i_d = i_q + ONE;
        else              i_d = i_q;
        addr_d = base_d + ADDR_W'(i_d);
        case (mode_d)
            MODE_CONST: data_d = fill_d;
            MODE_INDEX: data_d = DATA_W'(i_d);
            default:    data_d = '0;
        endcase
    end

    assign last = ((i_q + ONE) == len_q);

    // Request latches, counter and registered memory-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q        <= MODE_ZERO;
            base_q        <= '0;
            len_q         <= '0;
            fill_q        <= '0;
            mask_q        <= '0;
            i_q           <= '0;
            mem_input     <= '0;
            mem_address_i <= '0;
            write_enable  <= '0;
        end else begin
            mode_q <= mode_d;
            base_q <= base_d;
            len_q  <= len_d;
            fill_q <= fill_d;
            mask_q <= mask_d;
            i_q    <= i_d;
            if (write_next) begin
                mem_input     <= data_d;
                mem_address_i <= addr_d;
                write_enable  <= mask_d;
            end else begin
                mem_input     <= '0;
                mem_address_i <= '0;
                write_enable  <= '0;
            end
        end
    end

endmodule

// File: rtl/poly_mem_init_fsm.sv
// Control FSM: request acceptance, stall/abort handling, busy and done generation.
module poly_mem_init_fsm
    import poly_mem_init_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    input  logic stall,
    input  logic len_zero,
    input  logic last,
    output logic accept,
    output logic advance,
    output logic write_next,
    output logic busy,
    output logic write_done
);

    state_t state_q, state_d;

    // Next-state decode; advance marks an edge where the presented write moves on
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = len_zero ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!stall) begin
                    advance = 1'b1;
                    if (last) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign write_next = (state_d == ST_WRITE);

    // State plus registered busy/done, both derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            busy       <= 1'b0;
            write_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy       <= (state_d != ST_IDLE);
            write_done <= (state_d == ST_DONE);
        end
    end

endmodule

// File: rtl/poly_mem_init.sv
// Top: fills a contiguous coefficient region of one or more RAM banks.
module poly_mem_init
    import poly_mem_init_pkg::*;
#(
    parameter int unsigned DATA_W    = 26,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned NUM_BANKS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           mode,
    input  logic [ADDR_W-1:0]    base,
    input  logic [ADDR_W:0]      len,
    input  logic [DATA_W-1:0]    fill_value,
    input  logic [NUM_BANKS-1:0] bank_mask,
    input  logic                 stall,
    output logic [DATA_W-1:0]    mem_input,
    output logic [ADDR_W-1:0]    mem_address_i,
    output logic [NUM_BANKS-1:0] write_enable,
    output logic                 busy,
    output logic                 write_done
);

    logic accept;
    logic advance;
    logic write_next;
    logic last;

    poly_mem_init_fsm u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .stall      (stall),
        .len_zero   (len == '0),
        .last       (last),
        .accept     (accept),
        .advance    (advance),
        .write_next (write_next),
        .busy       (busy),
        .write_done (write_done)
    );

    poly_mem_init_dp #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .NUM_BANKS (NUM_BANKS)
    ) u_dp (
        .clk           (clk),
        .rst_n         (rst_n),
        .accept        (accept),
        .advance       (advance),
        .write_next    (write_next),
        .mode          (mode),
        .base          (base),
        .len           (len),
        .fill_value    (fill_value),
        .bank_mask     (bank_mask),
        .last          (last),
        .mem_input     (mem_input),
        .mem_address_i (mem_address_i),
        .write_enable  (write_enable)
    );

endmodule
